// File: rtl/drac_pkg.sv
// drac_pkg: shared instruction-queue sizing and entry layout
package drac_pkg;
  localparam int IQ_DEPTH = 8;
  localparam int IQ_LANES = 2;
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic [31:0] imm;
  } iq_entry_t;
endpackage

// File: rtl/iq_lane_rotator.sv
// iq_lane_rotator: maps pointer-relative lanes to storage slot indices
module iq_lane_rotator #(
  parameter int DEPTH = 8,
  parameter int LANES = 2,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic [PW-1:0]            base_i,
  output logic [LANES-1:0][PW-1:0] idx_o
);
  always_comb begin
    idx_o = '0;
    for (int k = 0; k < LANES; k++) idx_o[k] = base_i + PW'(k);
  end
endmodule

// File: rtl/multi_lane_instruction_queue.sv
// multi_lane_instruction_queue: circular queue with up to LANES pushes and pops per cycle
module multi_lane_instruction_queue import drac_pkg::*; #(
  parameter int DEPTH = IQ_DEPTH,
  parameter int WIDTH = $bits(iq_entry_t),
  parameter int LANES = IQ_LANES,
  parameter int AF_THRESH = DEPTH - LANES,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1,
  localparam int PCW = $clog2(LANES) + 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        flush_i,
  input  logic [LANES-1:0]            push_valid_i,
  input  logic [LANES-1:0][WIDTH-1:0] push_data_i,
  output logic                        push_ready_o,
  input  logic [PCW-1:0]              pop_count_i,
  output logic [LANES-1:0]            head_valid_o,
  output logic [LANES-1:0][WIDTH-1:0] head_data_o,
  output logic [CW-1:0]               count_o,
  output logic                        empty_o,
  output logic                        full_o,
  output logic                        almost_full_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d, n_push, n_acc, n_pop, pop_lim;
  logic [LANES-1:0][PW-1:0] rd_idx, wr_idx;
  iq_lane_rotator #(.DEPTH(DEPTH), .LANES(LANES)) u_rd_rot (.base_i(head_q), .idx_o(rd_idx));
  iq_lane_rotator #(.DEPTH(DEPTH), .LANES(LANES)) u_wr_rot (.base_i(tail_q), .idx_o(wr_idx));
  // Reset forces the full state so the front end stalls until released.
  assign push_ready_o  = !rst_i && (CW'(DEPTH) - count_q) >= CW'(LANES);
  assign count_o       = count_q;
  assign empty_o       = count_q == '0;
  assign full_o        = rst_i || count_q == CW'(DEPTH);
  assign almost_full_o = rst_i || count_q >= CW'(AF_THRESH);
  always_comb begin
    n_push = '0;
    for (int k = 0; k < LANES; k++) n_push = n_push + CW'(push_valid_i[k]);
    n_acc   = (push_ready_o && !flush_i) ? n_push : '0;
    pop_lim = count_q < CW'(LANES) ? count_q : CW'(LANES);
    n_pop   = CW'(pop_count_i) < pop_lim ? CW'(pop_count_i) : pop_lim;
    head_d  = flush_i ? '0 : head_q + PW'(n_pop);
    tail_d  = flush_i ? '0 : tail_q + PW'(n_acc);
    count_d = flush_i ? '0 : count_q + n_acc - n_pop;
  end
  always_comb begin
    head_valid_o = '0;
    head_data_o  = '0;
    for (int k = 0; k < LANES; k++) begin
      head_valid_o[k] = CW'(k) < count_q;
      head_data_o[k]  = head_valid_o[k] ? mem_q[rd_idx[k]] : '0;
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < LANES; k++)
      if (CW'(k) < n_acc) mem_q[wr_idx[k]] <= push_data_i[k];
  end
  // Lanes must fill from lane 0 upward with no holes.
  ap_push_contig: assert property (@(posedge clk_i) disable iff (rst_i)
    (push_valid_i & (push_valid_i + LANES'(1))) == '0);
endmodule

// File: tb/tb_multi_lane_instruction_queue.sv
// tb_multi_lane_instruction_queue: directed checks of fill, wrap, overflow, pop clipping, flush and reset
module tb_multi_lane_instruction_queue;
  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             flush_i = 1'b0;
  logic [1:0]       push_valid_i = '0;
  logic [1:0][127:0] push_data_i = '0;
  logic             push_ready_o;
  logic [1:0]       pop_count_i = '0;
  logic [1:0]       head_valid_o;
  logic [1:0][127:0] head_data_o;
  logic [3:0]       count_o;
  logic             empty_o, full_o, almost_full_o;
  int total = 0;
  int bad = 0;
  multi_lane_instruction_queue #(.DEPTH(8), .WIDTH(128), .LANES(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .push_valid_i(push_valid_i), .push_data_i(push_data_i), .push_ready_o(push_ready_o),
    .pop_count_i(pop_count_i), .head_valid_o(head_valid_o), .head_data_o(head_data_o),
    .count_o(count_o), .empty_o(empty_o), .full_o(full_o), .almost_full_o(almost_full_o)
  );
  always #5 clk_i = ~clk_i;
  function automatic logic [127:0] dv(input int n);
    return (n == 0) ? 128'd0 : {32'(n), 32'hC0DE0000, 32'(n * 3), 32'(n)};
  endfunction
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input logic [1:0] pv, input int a, input int b, input logic [1:0] pc, input logic fl);
    push_valid_i = pv;
    push_data_i[0] = dv(a);
    push_data_i[1] = dv(b);
    pop_count_i = pc;
    flush_i = fl;
    @(posedge clk_i);
    #1;
    push_valid_i = '0;
    pop_count_i = '0;
    flush_i = 1'b0;
  endtask
  task automatic hd(input string tag, input int cnt, input int a, input int b);
    chk({tag, ".count"}, 128'(count_o), 128'(cnt));
    chk({tag, ".valid"}, 128'(head_valid_o), (cnt >= 2) ? 128'd3 : (cnt == 1) ? 128'd1 : 128'd0);
    chk({tag, ".lane0"}, head_data_o[0], (cnt >= 1) ? dv(a) : 128'd0);
    chk({tag, ".lane1"}, head_data_o[1], (cnt >= 2) ? dv(b) : 128'd0);
  endtask
  initial begin
    repeat (2) @(posedge clk_i);
    #1;
    hd("rst", 0, 0, 0);
    chk("rst.empty", 128'(empty_o), 128'd1);
    chk("rst.full", 128'(full_o), 128'd1);
    chk("rst.af", 128'(almost_full_o), 128'd1);
    chk("rst.ready", 128'(push_ready_o), 128'd0);
    rst_i = 1'b0;
    #1;
    chk("idle.empty", 128'(empty_o), 128'd1);
    chk("idle.full", 128'(full_o), 128'd0);
    chk("idle.af", 128'(almost_full_o), 128'd0);
    chk("idle.ready", 128'(push_ready_o), 128'd1);
    cyc(2'b11, 1, 2, 0, 0);  hd("fill1", 2, 1, 2);
    chk("fill1.empty", 128'(empty_o), 128'd0);
    cyc(2'b11, 3, 4, 0, 0);  hd("fill2", 4, 1, 2);
    chk("fill2.af", 128'(almost_full_o), 128'd0);
    cyc(2'b11, 5, 6, 0, 0);  hd("fill3", 6, 1, 2);
    chk("fill3.af", 128'(almost_full_o), 128'd1);
    chk("fill3.ready", 128'(push_ready_o), 128'd1);
    chk("fill3.full", 128'(full_o), 128'd0);
    cyc(2'b11, 7, 8, 0, 0);  hd("fill4", 8, 1, 2);
    chk("fill4.full", 128'(full_o), 128'd1);
    chk("fill4.ready", 128'(push_ready_o), 128'd0);
    cyc(2'b00, 0, 0, 2, 0);  hd("pop1", 6, 3, 4);
    cyc(2'b00, 0, 0, 2, 0);  hd("pop2", 4, 5, 6);
    cyc(2'b00, 0, 0, 2, 0);  hd("pop3", 2, 7, 8);
    cyc(2'b11, 9, 10, 0, 0);  hd("wrap1", 4, 7, 8);
    cyc(2'b11, 11, 12, 0, 0); hd("wrap2", 6, 7, 8);
    cyc(2'b00, 0, 0, 2, 0);   hd("wrap3", 4, 9, 10);
    cyc(2'b00, 0, 0, 2, 0);   hd("wrap4", 2, 11, 12);
    cyc(2'b11, 13, 14, 0, 0); hd("sim1", 4, 11, 12);
    cyc(2'b11, 15, 16, 0, 0); hd("sim2", 6, 11, 12);
    cyc(2'b11, 17, 18, 2, 0); hd("sim3", 6, 13, 14);
    cyc(2'b00, 0, 0, 1, 0);   hd("ovf1", 5, 14, 15);
    cyc(2'b11, 19, 20, 0, 0); hd("ovf2", 7, 14, 15);
    chk("ovf2.ready", 128'(push_ready_o), 128'd0);
    chk("ovf2.full", 128'(full_o), 128'd0);
    cyc(2'b11, 21, 22, 0, 0); hd("ovf3", 7, 14, 15);
    cyc(2'b01, 21, 0, 0, 0);  hd("ovf4", 7, 14, 15);
    cyc(2'b00, 0, 0, 2, 0);   hd("drain1", 5, 16, 17);
    cyc(2'b00, 0, 0, 2, 0);   hd("drain2", 3, 18, 19);
    cyc(2'b00, 0, 0, 2, 0);   hd("drain3", 1, 20, 0);
    cyc(2'b00, 0, 0, 2, 0);   hd("overpop", 0, 0, 0);
    chk("overpop.empty", 128'(empty_o), 128'd1);
    cyc(2'b00, 0, 0, 3, 0);   hd("popempty", 0, 0, 0);
    cyc(2'b11, 1, 2, 0, 0);   hd("clip1", 2, 1, 2);
    cyc(2'b11, 3, 4, 0, 0);   hd("clip2", 4, 1, 2);
    cyc(2'b00, 0, 0, 3, 0);   hd("clip3", 2, 3, 4);
    cyc(2'b11, 5, 6, 0, 0);   hd("fl1", 4, 3, 4);
    cyc(2'b01, 7, 0, 0, 0);   hd("fl2", 5, 3, 4);
    cyc(2'b11, 8, 9, 0, 1);   hd("flush", 0, 0, 0);
    chk("flush.empty", 128'(empty_o), 128'd1);
    cyc(2'b01, 10, 0, 0, 0);  hd("postfl", 1, 10, 0);
    cyc(2'b11, 11, 12, 0, 0); hd("prerst", 3, 10, 11);
    #2 rst_i = 1'b1;
    #1;
    hd("midrst", 0, 0, 0);
    chk("midrst.empty", 128'(empty_o), 128'd1);
    chk("midrst.full", 128'(full_o), 128'd1);
    chk("midrst.af", 128'(almost_full_o), 128'd1);
    chk("midrst.ready", 128'(push_ready_o), 128'd0);
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    #1;
    chk("postrst.ready", 128'(push_ready_o), 128'd1);
    chk("postrst.full", 128'(full_o), 128'd0);
    cyc(2'b11, 13, 14, 0, 0); hd("postrst", 2, 13, 14);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
